// File: rtl/remux_if.sv
// remux_if: upstream word and downstream half-word handshake bundle
interface remux_if;
  logic [31:0] dataInput;
  logic        validIn;
  logic        readyOut;
  logic [15:0] dataOutput;
  logic        validOut;
  logic        readyIn;
  logic        lastHalf;
  modport master (
    output dataInput, validIn, readyIn,
    input  readyOut, dataOutput, validOut, lastHalf
  );
  modport slave (
    input  dataInput, validIn, readyIn,
    output readyOut, dataOutput, validOut, lastHalf
  );
endinterface

// File: rtl/remux.sv
// remux: splits each 32-bit sample word into two 16-bit half-words on a stream
module remux #(
  parameter bit HIGH_FIRST  = 1'b0,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   resetN,
  remux_if.slave                 bus,
  output logic [COUNT_WIDTH-1:0] wordCount
);
  typedef enum logic [1:0] {EMPTY, FIRST, SECOND} state_t;
  state_t      state, state_next;
  logic [31:0] word;
  logic        load, done;
  logic [15:0] half_a, half_b;
  assign half_a         = HIGH_FIRST ? word[31:16] : word[15:0];
  assign half_b         = HIGH_FIRST ? word[15:0] : word[31:16];
  assign bus.readyOut   = resetN && (state == EMPTY || (state == SECOND && bus.readyIn));
  assign load           = bus.validIn && bus.readyOut;
  assign done           = state == SECOND && bus.readyIn;
  assign bus.validOut   = state != EMPTY;
  assign bus.lastHalf   = state == SECOND;
  assign bus.dataOutput = state == FIRST ? half_a : state == SECOND ? half_b : 16'h0;
  // next state: a new word may replace the second half in the same cycle
  always_comb begin
    state_next = state;
    state_next = state == EMPTY  ? (bus.validIn ? FIRST : EMPTY) :
                 state == FIRST  ? (bus.readyIn ? SECOND : FIRST) :
                 state == SECOND ? (bus.readyIn ? (bus.validIn ? FIRST : EMPTY) : SECOND) :
                 EMPTY;
  end
  // state, held word and completed-word counter
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state     <= EMPTY;
      word      <= '0;
      wordCount <= '0;
    end else begin
      state <= state_next;
      if (load) word <= bus.dataInput;
      if (done) wordCount <= wordCount + COUNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_remux.sv
// tb_remux: directed vector checks for remux across three parameterisations
module tb_remux;
  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic [31:0] din = '0;
  logic        vin = 1'b0;
  logic        rin = 1'b0;
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;
  int          tests = 0;
  int          fails = 0;
  remux_if if0 ();
  remux_if if1 ();
  remux_if if2 ();
  assign if0.dataInput = din;
  assign if1.dataInput = din;
  assign if2.dataInput = din;
  assign if0.validIn = vin;
  assign if1.validIn = vin;
  assign if2.validIn = vin;
  assign if0.readyIn = rin;
  assign if1.readyIn = rin;
  assign if2.readyIn = rin;
  remux dut0 (.clock(clock), .resetN(resetN), .bus(if0), .wordCount(cnt0));
  remux #(.HIGH_FIRST(1'b1)) dut1 (.clock(clock), .resetN(resetN), .bus(if1), .wordCount(cnt1));
  remux #(.COUNT_WIDTH(4)) dut2 (.clock(clock), .resetN(resetN), .bus(if2), .wordCount(cnt2));
  always #5 clock = ~clock;
  typedef struct {
    logic [31:0] din;
    logic        vin;
    logic        rin;
    logic        ro;
    logic [15:0] dout;
    logic        vo;
    logic        lh;
    logic [15:0] cnt;
  } vec_t;
  vec_t vecs[18];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic reset_all();
    resetN = 1'b0;
    vin = 1'b0;
    rin = 1'b0;
    din = '0;
    #1;
    chk("rst_ro", 32'(if0.readyOut), 0);
    chk("rst_vo", 32'(if0.validOut), 0);
    chk("rst_lh", 32'(if0.lastHalf), 0);
    chk("rst_do", 32'(if0.dataOutput), 0);
    chk("rst_cnt", 32'(cnt0), 0);
    chk("rst_cnt4", 32'(cnt2), 0);
    tick();
    tick();
    @(negedge clock);
    resetN = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end
  initial begin
    vecs[0]  = '{32'hBEEF1234, 1, 1, 1, 16'h1234, 1, 0, 0};
    vecs[1]  = '{32'h00000000, 0, 1, 0, 16'hBEEF, 1, 1, 0};
    vecs[2]  = '{32'h00000000, 0, 1, 1, 16'h0000, 0, 0, 1};
    vecs[3]  = '{32'h00010002, 1, 1, 1, 16'h0002, 1, 0, 1};
    vecs[4]  = '{32'h00030004, 1, 1, 0, 16'h0001, 1, 1, 1};
    vecs[5]  = '{32'h00030004, 1, 1, 1, 16'h0004, 1, 0, 2};
    vecs[6]  = '{32'h00000000, 0, 1, 0, 16'h0003, 1, 1, 2};
    vecs[7]  = '{32'h00000000, 0, 1, 1, 16'h0000, 0, 0, 3};
    vecs[8]  = '{32'hAAAA5555, 1, 0, 1, 16'h5555, 1, 0, 3};
    vecs[9]  = '{32'hAAAA5555, 0, 0, 0, 16'h5555, 1, 0, 3};
    vecs[10] = '{32'h12345678, 1, 0, 0, 16'h5555, 1, 0, 3};
    vecs[11] = '{32'h00000000, 0, 0, 0, 16'h5555, 1, 0, 3};
    vecs[12] = '{32'h00000000, 0, 1, 0, 16'hAAAA, 1, 1, 3};
    vecs[13] = '{32'hCAFEF00D, 1, 0, 0, 16'hAAAA, 1, 1, 3};
    vecs[14] = '{32'hCAFEF00D, 1, 1, 1, 16'hF00D, 1, 0, 4};
    vecs[15] = '{32'h00000000, 0, 1, 0, 16'hCAFE, 1, 1, 4};
    vecs[16] = '{32'h00000000, 0, 1, 1, 16'h0000, 0, 0, 5};
    vecs[17] = '{32'h00000000, 0, 1, 1, 16'h0000, 0, 0, 5};
    reset_all();
    for (int i = 0; i < 18; i++) begin
      din = vecs[i].din;
      vin = vecs[i].vin;
      rin = vecs[i].rin;
      #1;
      chk($sformatf("v%0d_ro", i), 32'(if0.readyOut), 32'(vecs[i].ro));
      tick();
      chk($sformatf("v%0d_do", i), 32'(if0.dataOutput), 32'(vecs[i].dout));
      chk($sformatf("v%0d_vo", i), 32'(if0.validOut), 32'(vecs[i].vo));
      chk($sformatf("v%0d_lh", i), 32'(if0.lastHalf), 32'(vecs[i].lh));
      chk($sformatf("v%0d_cnt", i), 32'(cnt0), 32'(vecs[i].cnt));
    end
    reset_all();
    din = 32'hBEEF1234;
    vin = 1'b1;
    rin = 1'b1;
    tick();
    vin = 1'b0;
    chk("hf_first", 32'(if1.dataOutput), 32'h0000BEEF);
    chk("hf_first_lh", 32'(if1.lastHalf), 0);
    chk("lf_first", 32'(if0.dataOutput), 32'h00001234);
    tick();
    chk("hf_second", 32'(if1.dataOutput), 32'h00001234);
    chk("hf_second_lh", 32'(if1.lastHalf), 1);
    chk("lf_second", 32'(if0.dataOutput), 32'h0000BEEF);
    tick();
    chk("hf_done_cnt", 32'(cnt1), 1);
    reset_all();
    rin = 1'b1;
    for (int k = 0; k < 17; k++) begin
      din = 32'(k) * 32'h00010001;
      vin = 1'b1;
      #1;
      chk($sformatf("wrap%0d_ro", k), 32'(if0.readyOut), 1);
      tick();
      vin = 1'b0;
      if (k == 15) chk("wrap_cnt4_max", 32'(cnt2), 15);
      if (k == 16) chk("wrap_cnt4_zero", 32'(cnt2), 0);
      tick();
    end
    tick();
    chk("wrap_cnt4", 32'(cnt2), 1);
    chk("wrap_cnt16", 32'(cnt0), 17);
    din = 32'h11112222;
    vin = 1'b1;
    tick();
    vin = 1'b0;
    tick();
    chk("mid_lh", 32'(if0.lastHalf), 1);
    chk("mid_do", 32'(if0.dataOutput), 32'h00001111);
    resetN = 1'b0;
    #1;
    chk("mid_rst_do", 32'(if0.dataOutput), 0);
    chk("mid_rst_vo", 32'(if0.validOut), 0);
    chk("mid_rst_lh", 32'(if0.lastHalf), 0);
    chk("mid_rst_ro", 32'(if0.readyOut), 0);
    chk("mid_rst_cnt", 32'(cnt0), 0);
    tick();
    tick();
    @(negedge clock);
    resetN = 1'b1;
    tick();
    chk("post_rst_vo", 32'(if0.validOut), 0);
    chk("post_rst_cnt", 32'(cnt0), 0);
    din = 32'h5A5A0F0F;
    vin = 1'b1;
    #1;
    chk("post_rst_ro", 32'(if0.readyOut), 1);
    tick();
    vin = 1'b0;
    chk("post_rst_do", 32'(if0.dataOutput), 32'h00000F0F);
    chk("post_rst_vo1", 32'(if0.validOut), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/remux.md
REMUX -- requirements
Module: remux

Interface
REQ-001 Parameter HIGH_FIRST, default 0; 0 emits bits [15:0] before [31:16], 1 emits bits [31:16] first.
REQ-002 Parameter COUNT_WIDTH, default 16; width of the completed-word counter.
REQ-003 clock  input  1  single clock, all state updates on rising edge.
REQ-004 resetN  input  1  asynchronous, active-low reset; assertion takes effect immediately, deassertion is sampled on clock.
REQ-005 dataInput  input  32  sample word: [15:0] = channels sampled on clock, [31:16] = channels sampled on the 180-degree phase.
REQ-006 validIn  input  1  dataInput is valid this cycle.
REQ-007 readyOut  output  1  block accepts dataInput this cycle; a transfer occurs when validIn && readyOut.
REQ-008 dataOutput  output  16  current half-word presented downstream.
REQ-009 validOut  output  1  dataOutput is valid.
REQ-010 readyIn  input  1  downstream accepts dataOutput; a transfer occurs when validOut && readyIn.
REQ-011 lastHalf  output  1  high while the second half of a word is presented.
REQ-012 wordCount  output  COUNT_WIDTH  number of fully emitted words, modulo 2^COUNT_WIDTH.

Function
REQ-013 The block SHALL hold one 32-bit word register and a 3-state FSM: EMPTY, FIRST, SECOND.
REQ-014 EMPTY: validIn -> load dataInput, go to FIRST; otherwise stay.
REQ-015 FIRST: readyIn -> go to SECOND; otherwise hold state and word.
REQ-016 SECOND with readyIn && validIn -> load dataInput, go to FIRST (no bubble); readyIn && !validIn -> EMPTY; !readyIn -> hold.
REQ-017 readyOut SHALL equal (state==EMPTY) || (state==SECOND && readyIn); this is the only combinational input-to-output path.
REQ-018 validOut SHALL be high exactly when state is FIRST or SECOND; lastHalf SHALL be high exactly when state is SECOND.
REQ-019 dataOutput SHALL be word[15:0] in FIRST and word[31:16] in SECOND when HIGH_FIRST=0; the halves are swapped when HIGH_FIRST=1; it SHALL be 0 in EMPTY.
REQ-020 dataOutput SHALL depend only on registered state and the word register, never on dataInput directly.
REQ-021 A word accepted at edge N SHALL appear on dataOutput after edge N (latency 1 cycle); sustained throughput SHALL be one half-word per cycle when validIn and readyIn are held high.
REQ-022 While validOut && !readyIn, dataOutput, lastHalf and the word register SHALL remain stable.
REQ-023 wordCount SHALL increment by 1 on every SECOND-state transfer (validOut && readyIn && lastHalf) and wrap from all-ones to 0.
REQ-024 validIn while readyOut is low SHALL NOT alter the word register or state; upstream is required to hold dataInput.

Reset
REQ-025 While resetN is low: state=EMPTY, word register=0, dataOutput=0, validOut=0, lastHalf=0, wordCount=0, readyOut=0.
REQ-026 Reset asserted mid-word SHALL discard the held word without emitting its remaining half; wordCount SHALL not increment.
REQ-027 The first edge after resetN deasserts SHALL behave as EMPTY (readyOut=1, a valid word is accepted).

Verification
REQ-028 Single word 0xBEEF1234, readyIn=1, HIGH_FIRST=0 -> dataOutput 0x1234 (lastHalf=0), then 0xBEEF (lastHalf=1), then validOut=0, wordCount=1.
REQ-029 Streaming words 0x00010002, 0x00030004 back-to-back with readyIn=1 -> dataOutput 0x0002,0x0001,0x0004,0x0003 on consecutive cycles, readyOut high every second cycle.
REQ-030 readyIn held low 3 cycles while in FIRST with 0xAAAA5555 -> dataOutput stays 0x5555, readyOut=0, then resumes with 0xAAAA.
REQ-031 HIGH_FIRST=1, word 0xBEEF1234 -> dataOutput 0xBEEF first, then 0x1234.
REQ-032 COUNT_WIDTH=4, 17 words emitted -> wordCount reads 1 after wrap.
REQ-033 resetN pulsed low while in SECOND -> all outputs 0 immediately, no further half emitted, wordCount=0.
